aes_uart_rx: RTL and testbench
==============================

// Module: aes_uart_rx
// PURPOSE
//  Serial receive front-end of the AES test core. Deframes 8N1 UART bytes from
//  the io_rx pad input and buffers them in a small FIFO for the downstream
//  command/key/plaintext loader via a valid/ready byte stream.
//  Fully synchronous to clk. Reports framing errors and FIFO overflow as pulses.
// PARAMETERS
//  CYCLES_PER_BIT  16  clk cycles per UART bit; even, >=8
//  FIFO_DEPTH      4   byte FIFO entries; power of two, >=2
// PORTS
//  clk        in   1  core clock
//  reset      in   1  synchronous reset, active-low (0 = reset)
//  rx         in   1  asynchronous serial line from pad, idle high
//  data       out  8  FIFO head byte; valid only while data_valid=1
//  data_valid out  1  FIFO not empty
//  data_ready in   1  consumer accepts head byte when data_valid & data_ready
//  frame_err  out  1  1-cycle pulse: stop bit sampled low
//  overflow   out  1  1-cycle pulse: byte received while FIFO full, byte dropped
//  busy       out  1  receiver FSM not in IDLE
// BEHAVIOUR
//  Reset (reset=0 at clk edge): FSM=IDLE, counters 0, FIFO empty, sync flops=1.
//   data=0, data_valid=0, frame_err=0, overflow=0, busy=0.
//   Reset mid-frame aborts the frame; the partial byte is discarded.
//  Input sync: 2-FF synchronizer -> rx_s; all decisions use rx_s only.
//  Bit counter cnt counts 0..CYCLES_PER_BIT-1; bit index idx is 0..7.
//  FSM:
//   IDLE:  rx_s=0 -> START, cnt=0.
//   START: at cnt=CYCLES_PER_BIT/2-1 sample rx_s. If 1 (glitch) -> IDLE.
//          If 0 -> DATA, cnt=0, idx=0 (sample point now mid-bit).
//   DATA:  at cnt=CYCLES_PER_BIT-1 sample rx_s into shift[idx] (LSB first),
//          cnt=0. After idx=7 -> STOP, else idx+1.
//   STOP:  at cnt=CYCLES_PER_BIT-1 sample rx_s.
//          If 1: push byte; -> IDLE.
//          If 0: frame_err pulse next cycle; byte dropped; -> BREAK.
//   BREAK: wait for rx_s=1, then -> IDLE (no re-arm on a held-low line).
//  FIFO: push at stop-sample cycle; data_valid rises the next cycle.
//   Pop when data_valid & data_ready. data/data_valid are registered FIFO head.
//   Push while full without a pop in the same cycle: overflow pulse next cycle.
//   FIFO contents are unchanged by an overflowing push.
//   Simultaneous push and pop when full: both occur, no overflow.
//   Simultaneous push and pop when empty: push only (no bypass), valid next cycle.
//   Pointers wrap modulo FIFO_DEPTH; occupancy counter is clog2(DEPTH)+1 bits.
//  busy=1 in START, DATA, STOP and BREAK.
//  frame_err and overflow are never asserted in the same cycle for one byte.
// TESTING  (CYCLES_PER_BIT=16, FIFO_DEPTH=4, bit = 16 clk)
//  1. Send 0xA5 (8N1), data_ready=1:
//     -> one beat data=0xA5, no error pulses;
//     -> data_valid rises 2+8+8*16+16+1 (+/-1) cycles after rx falls.
//  2. Low pulse of 5 clk on idle rx:
//     -> FSM returns to IDLE; no data_valid, no frame_err.
//  3. Frame 0x3C with stop bit forced 0, rx held low 40 clk, then idle, then 0x11:
//     -> frame_err pulse once; only 0x11 delivered.
//  4. data_ready=0, send 0x01..0x05 back-to-back:
//     -> 4 bytes buffered; overflow pulse on the 5th.
//     -> Then data_ready=1 drains 0x01,0x02,0x03,0x04 in order.
//  5. FIFO full; stop-sample push coincides with a pop:
//     -> no overflow; order of delivered bytes preserved.
//  6. reset=0 for 1 cycle mid-DATA of 0x7E:
//     -> all outputs 0 next cycle, byte lost.
//     -> A following 0x42 frame is received correctly.

Source files
------------

// File: rtl/aes_uart_rx.sv
// 8N1 UART receive front-end for the AES test core: 2-FF input synchronizer,
// mid-bit sampling deframer and a small byte FIFO with valid/ready output.
module aes_uart_rx #(
    parameter int CYCLES_PER_BIT = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overflow,
    output logic       busy
);

    localparam int CNT_W = $clog2(CYCLES_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic             rx_meta_r;
    logic             rx_s_r;
    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [2:0]       idx_r;
    logic [2:0]       idx_next_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_next_s;
    logic             push_req_s;
    logic             ferr_s;

    logic [7:0]       mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_next_s;
    logic [PTR_W-1:0] rd_ptr_next_s;
    logic [OCC_W-1:0] occ_r;
    logic [OCC_W-1:0] occ_next_s;
    logic             pop_s;
    logic             full_s;
    logic             do_push_s;
    logic             ovf_s;
    logic [7:0]       head_next_s;

    logic [7:0]       data_r;
    logic             data_valid_r;
    logic             frame_err_r;
    logic             overflow_r;
    logic             busy_r;

    // Two-flop synchronizer for the asynchronous pad input
    always_ff @(posedge clk) begin
        if (!reset) begin
            rx_meta_r <= 1'b1;
            rx_s_r    <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_s_r    <= rx_meta_r;
        end
    end

    // Deframer next-state: START waits half a bit so later samples land mid-bit
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r + CNT_W'(1);
        idx_next_s   = idx_r;
        shift_next_s = shift_r;
        push_req_s   = 1'b0;
        ferr_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_next_s = CNT_W'(0);
                if (!rx_s_r) begin
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (cnt_r == CNT_HALF) begin
                    cnt_next_s = CNT_W'(0);
                    idx_next_s = 3'd0;
                    if (rx_s_r) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_START;
                end
            end
            ST_DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_next_s          = CNT_W'(0);
                    shift_next_s[idx_r] = rx_s_r;
                    if (idx_r == 3'd7) begin
                        state_next_s = ST_STOP;
                    end else begin
                        idx_next_s = idx_r + 3'd1;
                    end
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_next_s = CNT_W'(0);
                    if (rx_s_r) begin
                        push_req_s   = 1'b1;
                        state_next_s = ST_IDLE;
                    end else begin
                        ferr_s       = 1'b1;
                        state_next_s = ST_BREAK;
                    end
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_BREAK: begin
                cnt_next_s = CNT_W'(0);
                if (rx_s_r) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_BREAK;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_W'(0);
            end
        endcase
    end

    // Deframer state, bit counter, bit index and shift register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_W'(0);
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            idx_r   <= idx_next_s;
            shift_r <= shift_next_s;
        end
    end

    // FIFO control; an overflowing push leaves storage untouched
    always_comb begin
        pop_s         = data_valid_r & data_ready;
        full_s        = (occ_r == OCC_FULL);
        do_push_s     = push_req_s & (~full_s | pop_s);
        ovf_s         = push_req_s & full_s & ~pop_s;
        rd_ptr_next_s = rd_ptr_r;
        wr_ptr_next_s = wr_ptr_r;
        occ_next_s    = occ_r;
        head_next_s   = 8'h00;
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
        if (do_push_s) begin
            wr_ptr_next_s = wr_ptr_r + PTR_W'(1);
        end else begin
            wr_ptr_next_s = wr_ptr_r;
        end
        case ({do_push_s, pop_s})
            2'b10:   occ_next_s = occ_r + OCC_W'(1);
            2'b01:   occ_next_s = occ_r - OCC_W'(1);
            default: occ_next_s = occ_r;
        endcase
        // The incoming byte becomes the head when it lands in the slot read next
        if (occ_next_s == OCC_W'(0)) begin
            head_next_s = 8'h00;
        end else if (do_push_s && (rd_ptr_next_s == wr_ptr_r)) begin
            head_next_s = shift_r;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            occ_r    <= OCC_W'(0);
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= shift_r;
            end else begin
                mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
            end
            wr_ptr_r <= wr_ptr_next_s;
            rd_ptr_r <= rd_ptr_next_s;
            occ_r    <= occ_next_s;
        end
    end

    // Registered outputs: FIFO head, status and one-cycle error pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            data_r       <= 8'h00;
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            overflow_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            data_r       <= head_next_s;
            data_valid_r <= (occ_next_s != OCC_W'(0));
            frame_err_r  <= ferr_s;
            overflow_r   <= ovf_s;
            busy_r       <= (state_next_s != ST_IDLE);
        end
    end

    assign data       = data_r;
    assign data_valid = data_valid_r;
    assign frame_err  = frame_err_r;
    assign overflow   = overflow_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_aes_uart_rx.sv
// Directed-plus-random bench for aes_uart_rx; delivered bytes are compared
// against a queue of the bytes that the UART rules say must come out.
module tb_aes_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready = 1'b0;
    logic       frame_err;
    logic       overflow;
    logic       busy;

    int tests = 0;
    int fails = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int both_cnt = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    aes_uart_rx #(.CYCLES_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Consumer-side monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset) begin
            if (data_valid && data_ready) got_q.push_back(data);
            if (frame_err) fe_cnt++;
            if (overflow) ov_cnt++;
            if (frame_err && overflow) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), {24'h0, got_q[i]}, {24'h0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        idle(CPB);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        rx = 1'b1;
    endtask

    initial begin
        int n;
        int ov0;
        logic [7:0] b;
        logic [7:0] bs[5];

        // Reset state
        idle(3);
        check("rst_data", {24'h0, data}, 32'h0);
        check("rst_valid", {31'h0, data_valid}, 32'h0);
        check("rst_ferr", {31'h0, frame_err}, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        reset = 1'b1;
        idle(5);

        // 1: single byte, latency from falling start edge to data_valid
        data_ready = 1'b1;
        n = 0;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                while (!data_valid && n < 300) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
        join
        idle(4);
        check("t1_latency_in_window", {31'h0, (n >= 154 && n <= 156)}, 32'h1);
        exp_q.push_back(8'hA5);
        check_stream("t1");
        check("t1_no_ferr", fe_cnt, 0);

        // 2: 5-cycle glitch on idle line
        rx = 1'b0;
        idle(4);
        check("t2_busy_in_start", {31'h0, busy}, 32'h1);
        idle(1);
        rx = 1'b1;
        idle(40);
        check("t2_back_idle", {31'h0, busy}, 32'h0);
        check_stream("t2");
        check("t2_no_ferr", fe_cnt, 0);

        // 3: bad stop bit, held break, then a good frame
        send_byte(8'h3C, 1'b0);
        rx = 1'b0;
        idle(40);
        check("t3_busy_in_break", {31'h0, busy}, 32'h1);
        rx = 1'b1;
        idle(20);
        check("t3_idle_after_break", {31'h0, busy}, 32'h0);
        send_byte(8'h11, 1'b1);
        idle(4);
        check("t3_ferr_once", fe_cnt, 1);
        exp_q.push_back(8'h11);
        check_stream("t3");

        // 4: consumer stalled, five bytes into a four-entry FIFO
        data_ready = 1'b0;
        ov0 = ov_cnt;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        idle(4);
        check("t4_ovf_once", ov_cnt - ov0, 1);
        check("t4_valid", {31'h0, data_valid}, 32'h1);
        check("t4_head", {24'h0, data}, 32'h1);
        data_ready = 1'b1;
        idle(8);
        data_ready = 1'b0;
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        check_stream("t4");
        check("t4_ferr_unchanged", fe_cnt, 1);

        // 5: full FIFO, push at stop sample coincides with a one-cycle pop
        ov0 = ov_cnt;
        for (int i = 0; i < 5; i++) bs[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) send_byte(bs[i], 1'b1);
        idle(2);
        fork
            send_byte(bs[4], 1'b1);
            begin
                idle(154);
                data_ready = 1'b1;
                idle(1);
                data_ready = 1'b0;
            end
        join
        idle(4);
        check("t5_no_ovf", ov_cnt - ov0, 0);
        data_ready = 1'b1;
        idle(8);
        for (int i = 0; i < 5; i++) exp_q.push_back(bs[i]);
        check_stream("t5");

        // 6: reset mid-DATA discards the frame and the buffered byte
        data_ready = 1'b0;
        b = 8'($urandom);
        send_byte(b, 1'b1);
        idle(2);
        check("t6_buffered", {31'h0, data_valid}, 32'h1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        rx = 1'b1;
        idle(8);
        check("t6_busy_mid_data", {31'h0, busy}, 32'h1);
        reset = 1'b0;
        idle(1);
        check("t6_rst_valid", {31'h0, data_valid}, 32'h0);
        check("t6_rst_data", {24'h0, data}, 32'h0);
        check("t6_rst_busy", {31'h0, busy}, 32'h0);
        check("t6_rst_pulses", {30'h0, frame_err, overflow}, 32'h0);
        reset = 1'b1;
        idle(40);
        data_ready = 1'b1;
        send_byte(8'h42, 1'b1);
        idle(4);
        exp_q.push_back(8'h42);
        check_stream("t6");

        // 7: random back-to-back bytes with an always-ready consumer
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_byte(b, 1'b1);
        end
        idle(4);
        check_stream("t7");
        check("t7_ferr_total", fe_cnt, 1);
        check("no_coincident_pulses", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
